// File: rtl/grahzm8_alu_sequencer.sv
// Command-side driver for the Grah-8 ALU: byte-serial commands in, results out.
// Optional result flags (res_zero/res_neg) are enabled by GRAHZM8_SEQ_FLAGS_EN.
module grahzm8_alu_sequencer #(
    parameter int unsigned ALU_LAT    = 1,
    parameter int unsigned MAX_OPCODE = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] cmd_data,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    output logic [7:0] alu_in1,
    output logic [7:0] alu_in2,
    output logic [7:0] alu_instr,
    input  logic [7:0] alu_out,
    output logic [7:0] res_data,
    output logic       res_valid,
    input  logic       res_ready,
`ifdef GRAHZM8_SEQ_FLAGS_EN
    output logic       res_zero,
    output logic       res_neg,
`endif
    output logic       res_err
);

    typedef enum logic [2:0] {
        IDLE,
        GET_A,
        GET_B,
        ISSUE,
        RESULT
    } state_t;

    localparam logic [3:0] LAT = 4'(ALU_LAT);

    state_t     state_q, state_d;
    logic [6:0] op_q, op_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] in1_q, in1_d;
    logic [7:0] in2_q, in2_d;
    logic [7:0] instr_q, instr_d;
    logic [7:0] acc_q, acc_d;
    logic [7:0] rdata_q, rdata_d;
    logic       rvalid_q, rvalid_d;
    logic       rerr_q, rerr_d;
    logic       cready_q, cready_d;
`ifdef GRAHZM8_SEQ_FLAGS_EN
    logic       zero_q, zero_d;
    logic       neg_q, neg_d;
`endif

    logic cmd_fire;
    logic res_fire;
    logic op_legal;

    assign cmd_fire = cmd_valid & cready_q;
    assign res_fire = rvalid_q & res_ready;
    assign op_legal = (32'(op_q) <= MAX_OPCODE);

    // Next-state and datapath updates for the command/issue/result sequence
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        in1_d    = in1_q;
        in2_d    = in2_q;
        instr_d  = instr_q;
        acc_d    = acc_q;
        rdata_d  = rdata_q;
        rvalid_d = rvalid_q;
        rerr_d   = rerr_q;
`ifdef GRAHZM8_SEQ_FLAGS_EN
        zero_d   = zero_q;
        neg_d    = neg_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (cmd_fire) begin
                    op_d = cmd_data[6:0];
                    if (cmd_data[7]) begin
                        in1_d   = acc_q;
                        state_d = GET_B;
                    end else begin
                        state_d = GET_A;
                    end
                end
            end
            GET_A: begin
                if (cmd_fire) begin
                    in1_d   = cmd_data;
                    state_d = GET_B;
                end
            end
            GET_B: begin
                if (cmd_fire) begin
                    in2_d   = cmd_data;
                    instr_d = {1'b0, op_q};
                    if (op_legal) begin
                        cnt_d   = LAT;
                        state_d = ISSUE;
                    end else begin
                        rdata_d  = 8'h00;
                        rerr_d   = 1'b1;
                        rvalid_d = 1'b1;
`ifdef GRAHZM8_SEQ_FLAGS_EN
                        zero_d   = 1'b0;
                        neg_d    = 1'b0;
`endif
                        state_d  = RESULT;
                    end
                end
            end
            ISSUE: begin
                if (cnt_q == 4'd0) begin
                    rdata_d  = alu_out;
                    rerr_d   = 1'b0;
                    rvalid_d = 1'b1;
                    acc_d    = alu_out;
`ifdef GRAHZM8_SEQ_FLAGS_EN
                    zero_d   = (alu_out == 8'h00);
                    neg_d    = alu_out[7];
`endif
                    state_d  = RESULT;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESULT: begin
                if (res_fire) begin
                    rvalid_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        cready_d = (state_d == IDLE) || (state_d == GET_A) ||
                   (state_d == GET_B);
    end

    // State and registered outputs; reset discards any partial command
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            op_q     <= 7'd0;
            cnt_q    <= 4'd0;
            in1_q    <= 8'h00;
            in2_q    <= 8'h00;
            instr_q  <= 8'h00;
            acc_q    <= 8'h00;
            rdata_q  <= 8'h00;
            rvalid_q <= 1'b0;
            rerr_q   <= 1'b0;
            cready_q <= 1'b0;
`ifdef GRAHZM8_SEQ_FLAGS_EN
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            in1_q    <= in1_d;
            in2_q    <= in2_d;
            instr_q  <= instr_d;
            acc_q    <= acc_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            rerr_q   <= rerr_d;
            cready_q <= cready_d;
`ifdef GRAHZM8_SEQ_FLAGS_EN
            zero_q   <= zero_d;
            neg_q    <= neg_d;
`endif
        end
    end

    assign cmd_ready = cready_q;
    assign alu_in1   = in1_q;
    assign alu_in2   = in2_q;
    assign alu_instr = instr_q;
    assign res_data  = rdata_q;
    assign res_valid = rvalid_q;
    assign res_err   = rerr_q;
`ifdef GRAHZM8_SEQ_FLAGS_EN
    assign res_zero  = zero_q;
    assign res_neg   = neg_q;
`endif

endmodule
